lb_fifo_regs: RTL and testbench
===============================

# lb_fifo_regs

Local-bus register slave that sits directly downstream of the APB-to-local-bus bridge and consumes its write and read strobes. It exposes a CPU-accessible TX FIFO that drains to a valid/ready output stream, and an RX FIFO filled from a valid/ready input stream and popped by CPU reads. It also provides control and status registers, including sticky overflow and underflow flags.

## Interface
- ADDR_W, 16, local-bus address width (byte address)
- DEPTH, 8, entries per FIFO; power of two, 2..128
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- wready  out  1  write ready; constant 1 outside reset
- waddr  in  ADDR_W  write byte address
- wdata  in  32  write data
- wen  in  1  write strobe; write accepted when wen & wready
- wstrb  in  4  byte strobes
- raddr  in  ADDR_W  read byte address
- ren  in  1  read request; held by bridge until rvalid
- rdata  out  32  read data, registered
- rvalid  out  1  read response, one-cycle pulse
- tx_tdata  out  32  TX stream data (TX FIFO head)
- tx_tvalid  out  1  TX stream valid
- tx_tready  in  1  TX stream ready
- rx_tdata  in  32  RX stream data
- rx_tvalid  in  1  RX stream valid
- rx_tready  out  1  RX stream ready

## Operation
- Register map (full waddr/raddr compare; other addresses: writes ignored, reads return 0, no error):
  - 0x0 CTRL RW, honours wstrb: [0] TX_EN; [1] TX_FLUSH, write-1 self-clearing, reads 0; [2] RX_FLUSH, same as TX_FLUSH. Reset 0.
  - 0x4 TXDATA WO: a write with wstrb != 0 pushes the full wdata. If TX is full, the word is dropped and TX_OVF is set. Reads return 0.
  - 0x8 RXDATA RO: a read pops the RX head into rdata. If RX is empty, rdata=0 and RX_UNF is set. Writes ignored.
  - 0xC STATUS:
    - [0] TX_FULL, [1] TX_EMPTY, [2] RX_FULL, [3] RX_EMPTY.
    - [4] TX_OVF, [5] RX_UNF: sticky; cleared by writing 1 with wstrb[0]=1.
    - [23:16] TX_CNT, [31:24] RX_CNT.
    - Other bits read 0.
- TX FIFO:
  - tx_tvalid = TX_EN & !TX_EMPTY; tx_tdata = head entry.
  - Pop on tx_tvalid & tx_tready.
- RX FIFO:
  - rx_tready = !RX_FULL.
  - Push on rx_tvalid & rx_tready.
- Counts are 8-bit, range 0..DEPTH. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- FULL = (cnt == DEPTH); EMPTY = (cnt == 0). Both are derived from the registered count.

## Timing
- Reset values: wready=0, rdata=0, rvalid=0, tx_tvalid=0, rx_tready=0. All pointers, counts, CTRL and sticky flags are 0.
- Leaving reset: wready=1 and rx_tready=1 from the first clk edge after rst deasserts.
- Write: takes effect at the clk edge where wen & wready. There is no write latency visible on the bus.
- Read acceptance:
  - A read is accepted on a cycle with ren=1 and rvalid=0.
  - rdata/rvalid update at the next edge; rvalid is high for exactly one cycle.
  - ren seen while rvalid=1 is ignored, so a held ren never double-pops.
- Pop/sample point: the RXDATA pop and the STATUS sample both occur at the acceptance edge.
- Same-cycle events:
  - CPU push and stream pop on TX in the same cycle: both happen. The full check uses the pre-edge count, so a push to a full FIFO is dropped even if a pop occurs that cycle.
  - Stream push and CPU pop on RX in the same cycle: both happen, and the count is unchanged.
  - Flush versus push/pop in the same cycle: flush wins. The count becomes 0, pointers are reset, the concurrent push is discarded, and the sticky flags are unaffected.
  - Sticky clear and sticky set in the same cycle: set wins.
- TX_EN=0 holds tx_tvalid low; FIFO contents are retained.
- Reset asserted mid-transfer clears everything asynchronously. An in-flight rvalid is not produced.

## Test plan
- Reset then idle: rst low 5 cycles -> all outputs 0. After release: wready=1, rx_tready=1. STATUS reads 0x0000_000A.
- CTRL=0 (TX_EN=0): push 0x11, 0x22, 0x33 to TXDATA -> STATUS TX_CNT=3. Then set CTRL=0x1 with tx_tready=1 -> tx_tdata 0x11, 0x22, 0x33 on consecutive cycles, then tx_tvalid=0.
- DEPTH=8 with TX_EN=0: 9 pushes 0xA0..0xA8 -> TX_FULL=1 and TX_OVF=1. After enabling TX, 0xA8 never appears. Write 0x10 to STATUS -> TX_OVF=0.
- RX stream: drive 0xDEADBEEF then 0xCAFEF00D, then read RXDATA twice -> rvalid pulses return those values in order, each one cycle after acceptance. A third read returns 0 and STATUS RX_UNF=1.
- RX full backpressure: with rx_tvalid held high, 8 words fill RX and rx_tready=0. A single RXDATA read -> rx_tready=1 for one cycle, one word accepted, RX_CNT returns to 8.
- Flush and reset: TX holds 4 words; write CTRL=0x2 concurrently with tx handshake -> TX_CNT=0, CTRL reads 0. Async rst pulse during a held ren -> rvalid stays 0 and counts are 0.

Source files
------------

// File: rtl/lb_fifo_regs.sv
// lb_fifo_regs
// Local-bus register slave with a CPU-fed TX FIFO that drains to a
// valid/ready stream, and a stream-fed RX FIFO that the CPU pops by reading.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   wready          write ready, 1 whenever out of reset
//   waddr/wdata/wen/wstrb   local-bus write (accepted on wen & wready)
//   raddr/ren       local-bus read request (held by the bridge until rvalid)
//   rdata/rvalid    registered read response, rvalid is a one-cycle pulse
//   tx_tdata/tx_tvalid/tx_tready   TX stream out (head of TX FIFO)
//   rx_tdata/rx_tvalid/rx_tready   RX stream in (tail of RX FIFO)
//
// Register map (byte addresses, full compare):
//   0x0 CTRL   [0] TX_EN, [1] TX_FLUSH (W1, reads 0), [2] RX_FLUSH (W1, reads 0)
//   0x4 TXDATA write pushes wdata into the TX FIFO
//   0x8 RXDATA read pops the RX FIFO head
//   0xC STATUS [0] TX_FULL [1] TX_EMPTY [2] RX_FULL [3] RX_EMPTY
//              [4] TX_OVF [5] RX_UNF (sticky, W1C) [23:16] TX_CNT [31:24] RX_CNT
module lb_fifo_regs #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              wready,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              wen,
    input  logic [3:0]        wstrb,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              ren,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic [31:0]       tx_tdata,
    output logic              tx_tvalid,
    input  logic              tx_tready,
    input  logic [31:0]       rx_tdata,
    input  logic              rx_tvalid,
    output logic              rx_tready
);

    localparam int               PTR_W       = $clog2(DEPTH);
    localparam logic [7:0]       DEPTH_CNT   = 8'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(32'h0);
    localparam logic [ADDR_W-1:0] ADDR_TXDATA = ADDR_W'(32'h4);
    localparam logic [ADDR_W-1:0] ADDR_RXDATA = ADDR_W'(32'h8);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(32'hC);

    logic             active;
    logic             tx_en;
    logic             tx_ovf;
    logic             rx_unf;

    logic [31:0]      tx_mem [DEPTH];
    logic [31:0]      rx_mem [DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [7:0]       tx_cnt, rx_cnt;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic wr_fire, ctrl_wr, status_wr;
    logic tx_flush, rx_flush;
    logic tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic rx_push, rx_pop, rx_unf_set;
    logic rd_accept, rd_rxdata;
    logic [31:0] status_word;
    logic [31:0] rd_word;

    // Flags come from the registered counts only, so a same-cycle pop never
    // makes room for a same-cycle push.
    assign tx_full  = (tx_cnt == DEPTH_CNT);
    assign tx_empty = (tx_cnt == 8'd0);
    assign rx_full  = (rx_cnt == DEPTH_CNT);
    assign rx_empty = (rx_cnt == 8'd0);

    assign wready    = active;
    assign wr_fire   = wen & wready;
    assign ctrl_wr   = wr_fire & (waddr == ADDR_CTRL) & wstrb[0];
    assign status_wr = wr_fire & (waddr == ADDR_STATUS) & wstrb[0];
    assign tx_flush  = ctrl_wr & wdata[1];
    assign rx_flush  = ctrl_wr & wdata[2];

    assign tx_push_req = wr_fire & (waddr == ADDR_TXDATA) & (|wstrb);
    assign tx_push     = tx_push_req & ~tx_full;
    assign tx_ovf_set  = tx_push_req & tx_full;
    assign tx_tvalid   = tx_en & ~tx_empty;
    assign tx_tdata    = tx_mem[tx_rd_ptr];
    assign tx_pop      = tx_tvalid & tx_tready;

    // A read is taken only while no response is outstanding, which keeps a
    // held ren from popping twice.
    assign rd_accept  = ren & ~rvalid;
    assign rd_rxdata  = rd_accept & (raddr == ADDR_RXDATA);
    assign rx_pop     = rd_rxdata & ~rx_empty;
    assign rx_unf_set = rd_rxdata & rx_empty;
    assign rx_tready  = active & ~rx_full;
    assign rx_push    = rx_tvalid & rx_tready;

    assign status_word = {rx_cnt, tx_cnt, 10'h0, rx_unf, tx_ovf,
                          rx_empty, rx_full, tx_empty, tx_full};

    // Read data mux; unmapped and write-only addresses read as zero.
    always_comb begin
        rd_word = 32'h0;
        if (raddr == ADDR_RXDATA) begin
            rd_word = rx_empty ? 32'h0 : rx_mem[rx_rd_ptr];
        end else if (raddr == ADDR_CTRL) begin
            rd_word = {31'h0, tx_en};
        end else if (raddr == ADDR_STATUS) begin
            rd_word = status_word;
        end
    end

    // Control and sticky flags. A set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            tx_en  <= 1'b0;
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            active <= 1'b1;
            if (ctrl_wr) begin
                tx_en <= wdata[0];
            end
            tx_ovf <= (tx_ovf & ~(status_wr & wdata[4])) | tx_ovf_set;
            rx_unf <= (rx_unf & ~(status_wr & wdata[5])) | rx_unf_set;
        end
    end

    // TX FIFO pointers and count; a flush overrides any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= 8'd0;
        end else if (tx_flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= 8'd0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
            end
            tx_cnt <= tx_cnt + 8'(tx_push) - 8'(tx_pop);
        end
    end

    // RX FIFO pointers and count; a flush overrides any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= 8'd0;
        end else if (rx_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= 8'd0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
            end
            rx_cnt <= rx_cnt + 8'(rx_push) - 8'(rx_pop);
        end
    end

    // FIFO storage needs no reset; a write landing during a flush is
    // unreachable because the pointers restart at zero.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= wdata;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_tdata;
        end
    end

    // Registered read response, produced one edge after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= 32'h0;
        end else begin
            rvalid <= rd_accept;
            if (rd_accept) begin
                rdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_lb_fifo_regs.sv
// tb_lb_fifo_regs
// Self-checking bench for lb_fifo_regs: directed scenarios followed by a
// randomized run compared against a queue-based reference model.
module tb_lb_fifo_regs;

    localparam int          ADDR_W   = 16;
    localparam int          DEPTH    = 8;
    localparam logic [15:0] A_CTRL   = 16'h0;
    localparam logic [15:0] A_TX     = 16'h4;
    localparam logic [15:0] A_RX     = 16'h8;
    localparam logic [15:0] A_ST     = 16'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wready;
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wstrb;
    logic [15:0] raddr;
    logic        ren;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [31:0] rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;

    int total = 0;
    int bad   = 0;

    lb_fifo_regs #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wready(wready), .waddr(waddr), .wdata(wdata),
        .wen(wen), .wstrb(wstrb), .raddr(raddr), .ren(ren), .rdata(rdata),
        .rvalid(rvalid), .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid),
        .tx_tready(tx_tready), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
        .rx_tready(rx_tready)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        wen = 1'b0; wstrb = 4'h0; waddr = 16'h0; wdata = 32'h0;
        ren = 1'b0; raddr = 16'h0;
        tx_tready = 1'b0; rx_tvalid = 1'b0; rx_tdata = 32'h0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        waddr = a; wdata = d; wstrb = s; wen = 1'b1;
        tick();
        wen = 1'b0; wstrb = 4'h0;
    endtask

    // Returns x unless rvalid pulses exactly one cycle after acceptance.
    task automatic cpu_read(input logic [15:0] a, output logic [31:0] d);
        raddr = a; ren = 1'b1;
        tick();
        d = rvalid ? rdata : 32'hxxxx_xxxx;
        ren = 1'b0;
        tick();
        if (rvalid !== 1'b0) d = 32'hxxxx_xxxx;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        idle_inputs();
        rst = 1'b0;
        repeat (5) tick();
        total++;
        if ({wready, rvalid, tx_tvalid, rx_tready} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000", {wready, rvalid, tx_tvalid, rx_tready});
        end
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({wready, rx_tready} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL release_ready: got %b expected 11", {wready, rx_tready});
        end
        cpu_read(A_ST, d);
        total++;
        if (d !== 32'h0000_000A) begin
            bad++;
            $display("[TB] FAIL reset_status: got %h expected 0000000a", d);
        end
    endtask

    task automatic test_tx_order;
        logic [31:0] d;
        logic [31:0] exp_words [3];
        exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
        cpu_write(A_CTRL, 32'h0, 4'h1);
        for (int i = 0; i < 3; i++) cpu_write(A_TX, exp_words[i], 4'hF);
        cpu_read(A_ST, d);
        total++;
        if (d !== 32'h0003_0008) begin
            bad++;
            $display("[TB] FAIL tx_cnt3_status: got %h expected 00030008", d);
        end
        tx_tready = 1'b1;
        cpu_write(A_CTRL, 32'h1, 4'h1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (tx_tvalid !== 1'b1 || tx_tdata !== exp_words[i]) begin
                bad++;
                $display("[TB] FAIL tx_order[%0d]: got v=%b d=%h expected v=1 d=%h", i, tx_tvalid, tx_tdata, exp_words[i]);
            end
            tick();
        end
        total++;
        if (tx_tvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL tx_drained: got %b expected 0", tx_tvalid);
        end
        tx_tready = 1'b0;
        cpu_write(A_CTRL, 32'h0, 4'h1);
    endtask

    task automatic test_tx_overflow;
        logic [31:0] d;
        for (int i = 0; i < 9; i++) cpu_write(A_TX, 32'hA0 + 32'(i), 4'hF);
        cpu_read(A_ST, d);
        total++;
        if (d !== 32'h0008_0019) begin
            bad++;
            $display("[TB] FAIL tx_ovf_status: got %h expected 00080019", d);
        end
        tx_tready = 1'b1;
        cpu_write(A_CTRL, 32'h1, 4'h1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (tx_tvalid !== 1'b1 || tx_tdata !== 32'hA0 + 32'(i)) begin
                bad++;
                $display("[TB] FAIL tx_full_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, tx_tvalid, tx_tdata, 32'hA0 + 32'(i));
            end
            tick();
        end
        total++;
        if (tx_tvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL tx_dropped_word: got v=%b d=%h expected v=0", tx_tvalid, tx_tdata);
        end
        tx_tready = 1'b0;
        cpu_write(A_CTRL, 32'h0, 4'h1);
        cpu_write(A_ST, 32'h10, 4'h1);
        cpu_read(A_ST, d);
        total++;
        if (d !== 32'h0000_000A) begin
            bad++;
            $display("[TB] FAIL tx_ovf_clear: got %h expected 0000000a", d);
        end
    endtask

    task automatic test_rx_stream;
        logic [31:0] d;
        rx_tvalid = 1'b1; rx_tdata = 32'hDEAD_BEEF;
        tick();
        rx_tdata = 32'hCAFE_F00D;
        tick();
        rx_tvalid = 1'b0;
        cpu_read(A_RX, d);
        total++;
        if (d !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL rx_first: got %h expected deadbeef", d);
        end
        cpu_read(A_RX, d);
        total++;
        if (d !== 32'hCAFE_F00D) begin
            bad++;
            $display("[TB] FAIL rx_second: got %h expected cafef00d", d);
        end
        cpu_read(A_RX, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("[TB] FAIL rx_empty_read: got %h expected 00000000", d);
        end
        cpu_read(A_ST, d);
        total++;
        if (d !== 32'h0000_002A) begin
            bad++;
            $display("[TB] FAIL rx_unf_status: got %h expected 0000002a", d);
        end
        cpu_write(A_ST, 32'h20, 4'h1);
    endtask

    task automatic test_rx_backpressure;
        logic [31:0] d;
        rx_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_tdata = 32'h100 + 32'(i);
            tick();
        end
        rx_tdata = 32'h200;
        total++;
        if (rx_tready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rx_full_ready: got %b expected 0", rx_tready);
        end
        raddr = A_RX; ren = 1'b1;
        tick();
        ren = 1'b0;
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'h100 || rx_tready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rx_pop_full: got v=%b d=%h rdy=%b expected v=1 d=00000100 rdy=1", rvalid, rdata, rx_tready);
        end
        tick();
        rx_tvalid = 1'b0;
        total++;
        if (rx_tready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rx_refill_ready: got %b expected 0", rx_tready);
        end
        cpu_read(A_ST, d);
        total++;
        if (d !== 32'h0800_0006) begin
            bad++;
            $display("[TB] FAIL rx_full_status: got %h expected 08000006", d);
        end
        cpu_write(A_CTRL, 32'h4, 4'h1);
        cpu_read(A_ST, d);
        total++;
        if (d !== 32'h0000_000A) begin
            bad++;
            $display("[TB] FAIL rx_flush_status: got %h expected 0000000a", d);
        end
    endtask

    task automatic test_flush;
        logic [31:0] d;
        for (int i = 1; i <= 4; i++) cpu_write(A_TX, 32'(i), 4'hF);
        tx_tready = 1'b1;
        cpu_write(A_CTRL, 32'h1, 4'h1);
        total++;
        if (tx_tvalid !== 1'b1 || tx_tdata !== 32'h1) begin
            bad++;
            $display("[TB] FAIL flush_pre: got v=%b d=%h expected v=1 d=00000001", tx_tvalid, tx_tdata);
        end
        cpu_write(A_CTRL, 32'h2, 4'h1);
        tx_tready = 1'b0;
        cpu_read(A_ST, d);
        total++;
        if (d !== 32'h0000_000A) begin
            bad++;
            $display("[TB] FAIL flush_status: got %h expected 0000000a", d);
        end
        cpu_read(A_CTRL, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("[TB] FAIL flush_ctrl: got %h expected 00000000", d);
        end
        cpu_write(A_TX, 32'h99, 4'hF);
        cpu_write(A_CTRL, 32'h1, 4'h1);
        total++;
        if (tx_tvalid !== 1'b1 || tx_tdata !== 32'h99) begin
            bad++;
            $display("[TB] FAIL flush_restart: got v=%b d=%h expected v=1 d=00000099", tx_tvalid, tx_tdata);
        end
        cpu_write(A_CTRL, 32'h2, 4'h1);
    endtask

    task automatic test_reset_midread;
        logic [31:0] d;
        rx_tvalid = 1'b1; rx_tdata = 32'h5555;
        tick();
        rx_tvalid = 1'b0;
        cpu_write(A_TX, 32'h77, 4'hF);
        raddr = A_RX; ren = 1'b1;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({rvalid, wready, rx_tready} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL async_reset: got %b expected 000", {rvalid, wready, rx_tready});
        end
        tick();
        total++;
        if (rvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid);
        end
        ren = 1'b0;
        rst = 1'b1;
        tick();
        cpu_read(A_ST, d);
        total++;
        if (d !== 32'h0000_000A) begin
            bad++;
            $display("[TB] FAIL reset_counts: got %h expected 0000000a", d);
        end
    endtask

    task automatic test_random;
        logic [31:0] tx_q[$];
        logic [31:0] rx_q[$];
        logic [15:0] rd_addrs [6];
        logic [15:0] junk_addrs [3];
        logic        m_en, m_ovf, m_unf;
        logic        exp_rv, push_req, ovf_set, unf_set, clr_o, clr_u;
        logic [31:0] exp_rd, st;
        int          k, txn, rxn;
        rd_addrs[0] = A_RX; rd_addrs[1] = A_RX; rd_addrs[2] = A_ST;
        rd_addrs[3] = A_CTRL; rd_addrs[4] = A_TX; rd_addrs[5] = 16'h0006;
        junk_addrs[0] = A_RX; junk_addrs[1] = 16'h0010; junk_addrs[2] = 16'h0002;
        m_en = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; exp_rv = 1'b0; exp_rd = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            wen = 1'b0; wstrb = 4'h0; waddr = 16'h0; wdata = $urandom;
            ren = 1'b0; raddr = 16'h0;
            k = $urandom_range(0, 9);
            if (k < 4) begin
                wen = 1'b1; waddr = A_TX;
                wstrb = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end else if (k == 4) begin
                wen = 1'b1; waddr = A_CTRL; wstrb = 4'($urandom_range(0, 15));
                wdata[0] = ($urandom_range(0, 3) != 0);
                wdata[1] = ($urandom_range(0, 7) == 0);
                wdata[2] = ($urandom_range(0, 7) == 0);
            end else if (k == 5) begin
                wen = 1'b1; waddr = A_ST; wstrb = 4'($urandom_range(0, 15));
            end else if (k == 6) begin
                wen = 1'b1; waddr = junk_addrs[$urandom_range(0, 2)]; wstrb = 4'hF;
            end
            if (!exp_rv && $urandom_range(0, 2) == 0) begin
                ren = 1'b1;
                raddr = rd_addrs[$urandom_range(0, 5)];
            end
            tx_tready = 1'($urandom_range(0, 1));
            rx_tvalid = 1'($urandom_range(0, 1));
            rx_tdata  = $urandom;

            txn = tx_q.size();
            rxn = rx_q.size();
            total++;
            if (tx_tvalid !== (m_en && txn > 0)) begin
                bad++;
                $display("[TB] FAIL rand_tx_valid@%0d: got %b expected %b", cyc, tx_tvalid, (m_en && txn > 0));
            end
            if (m_en && txn > 0) begin
                total++;
                if (tx_tdata !== tx_q[0]) begin
                    bad++;
                    $display("[TB] FAIL rand_tx_data@%0d: got %h expected %h", cyc, tx_tdata, tx_q[0]);
                end
            end
            total++;
            if (rx_tready !== (rxn < DEPTH)) begin
                bad++;
                $display("[TB] FAIL rand_rx_ready@%0d: got %b expected %b", cyc, rx_tready, (rxn < DEPTH));
            end

            st = (32'(rxn) << 24) | (32'(txn) << 16) | (32'(m_unf) << 5) | (32'(m_ovf) << 4)
               | (32'(rxn == 0) << 3) | (32'(rxn == DEPTH) << 2) | (32'(txn == 0) << 1) | 32'(txn == DEPTH);
            unf_set = 1'b0;
            if (ren) begin
                exp_rd = 32'h0;
                if (raddr == A_RX) begin
                    if (rxn > 0) exp_rd = rx_q.pop_front();
                    else unf_set = 1'b1;
                end else if (raddr == A_ST) begin
                    exp_rd = st;
                end else if (raddr == A_CTRL) begin
                    exp_rd = {31'h0, m_en};
                end
            end
            if (m_en && txn > 0 && tx_tready) void'(tx_q.pop_front());
            push_req = wen && waddr == A_TX && wstrb != 4'h0;
            ovf_set  = push_req && txn == DEPTH;
            if (push_req && txn < DEPTH) tx_q.push_back(wdata);
            if (rx_tvalid && rxn < DEPTH) rx_q.push_back(rx_tdata);
            if (wen && waddr == A_CTRL && wstrb[0]) begin
                m_en = wdata[0];
                if (wdata[1]) tx_q.delete();
                if (wdata[2]) rx_q.delete();
            end
            clr_o = wen && waddr == A_ST && wstrb[0] && wdata[4];
            clr_u = wen && waddr == A_ST && wstrb[0] && wdata[5];
            m_ovf = (m_ovf && !clr_o) || ovf_set;
            m_unf = (m_unf && !clr_u) || unf_set;
            exp_rv = ren;

            tick();
            total++;
            if (rvalid !== exp_rv) begin
                bad++;
                $display("[TB] FAIL rand_rvalid@%0d: got %b expected %b", cyc, rvalid, exp_rv);
            end
            if (exp_rv) begin
                total++;
                if (rdata !== exp_rd) begin
                    bad++;
                    $display("[TB] FAIL rand_rdata@%0d: got %h expected %h", cyc, rdata, exp_rd);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_tx_order();
        test_tx_overflow();
        test_rx_stream();
        test_rx_backpressure();
        test_flush();
        test_reset_midread();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
